// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo: stereo I2S / left-justified slave transmitter.
// Takes L/R samples through a valid/ready handshake into a one-frame holding
// buffer and shifts them MSB-first onto i2s_din, clocked by the codec's
// sclk/lrclk. Slots longer than WIDTH are padded with zeros, and shorter slots
// are truncated. A frame that starts with the buffer empty sends silence and
// pulses underrun.
module i2s_tx_stereo #(
    parameter int WIDTH = 16,   // sample width, 8..32
    parameter int MODE  = 0     // 0 = I2S, 1 = left-justified
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] IN_L,
    input  logic [WIDTH-1:0] IN_R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             i2s_sclk,
    input  logic             i2s_lrclk,
    output logic             i2s_din,
    output logic             i2s_sampled,
    output logic             underrun
);

    // Place a sample at the top of a 32-bit slot word, zero-filled below.
    function automatic logic [31:0] align_msb(input logic [WIDTH-1:0] s);
        logic [31:0] t;
        t = '0;
        t[31 -: WIDTH] = s;
        return t;
    endfunction

    logic [1:0]       sclk_sync, lr_sync;
    logic             sclk_d, lr_q;
    logic             sclk_rise, sclk_fall;
    logic             w;
    logic             buf_full;
    logic [WIDTH-1:0] buf_l, buf_r;
    logic [31:0]      r_hold, shift;
    logic             hold_off;
    logic             din_q, sampled_q, underrun_q;

    logic             eval_edge, word_start, left_word;
    logic             load_left, load_right, shift_en;

    // Synchronise sclk/lrclk and turn the synced sclk into registered edge pulses.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the values that were present before the edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sclk_d    <= 1'b0;
            lr_q      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], i2s_sclk};
            lr_sync   <= {lr_sync[0], i2s_lrclk};
            sclk_d    <= sclk_sync[1];
            // lr_q is delayed to line up with the edge pulses it is evaluated with.
            lr_q      <= lr_sync[1];
            sclk_rise <= sclk_sync[1] & ~sclk_d;
            sclk_fall <= ~sclk_sync[1] & sclk_d;
        end
    end

    // Decode word boundaries and the shift strobe from the edge pulses.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        eval_edge  = 1'b0;
        word_start = 1'b0;
        left_word  = 1'b0;
        load_left  = 1'b0;
        load_right = 1'b0;
        shift_en   = 1'b0;
        eval_edge  = (MODE == 0) ? sclk_rise : sclk_fall;
        word_start = eval_edge && (lr_q != w);
        left_word  = (MODE == 0) ? ~lr_q : lr_q;
        load_left  = word_start & left_word;
        load_right = word_start & ~left_word;
        // A word start on the same fall takes precedence over shifting.
        shift_en   = sclk_fall & ~word_start;
    end

    // Holding buffer: filled by the handshake, drained by each left-word load.
    // NOTE: the sample registers are reset as well, so that the data path is
    // fully defined straight out of reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
        end else if (in_valid && in_ready) begin
            buf_full <= 1'b1;
            buf_l    <= IN_L;
            buf_r    <= IN_R;
        end else if (load_left) begin
            buf_full <= 1'b0;
        end
    end

    assign in_ready = ~buf_full;

    // Track the last evaluated lrclk level, and load or shift the slot register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            w        <= 1'b0;
            shift    <= '0;
            r_hold   <= '0;
            hold_off <= 1'b0;
        end else begin
            if (eval_edge) begin
                w <= lr_q;
            end
            if (load_left) begin
                shift  <= buf_full ? align_msb(buf_l) : '0;
                r_hold <= buf_full ? align_msb(buf_r) : '0;
            end else if (load_right) begin
                shift <= r_hold;
            end else if (shift_en && !hold_off) begin
                shift <= {shift[30:0], 1'b0};
            end
            // In I2S mode the load happens on a rise, half a bit before the
            // fall that would normally advance the shift. That first fall is
            // skipped so the MSB is held for a full bit time, one sclk after
            // the lrclk edge.
            if (word_start) begin
                hold_off <= (MODE == 0);
            end else if (shift_en) begin
                hold_off <= 1'b0;
            end
        end
    end

    // Register the serial output and the frame-start / underrun pulses.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            din_q      <= 1'b0;
            sampled_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            din_q      <= shift[31];
            sampled_q  <= load_left;
            underrun_q <= load_left & ~buf_full;
        end
    end

    assign i2s_din     = din_q;
    assign i2s_sampled = sampled_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Testbench for i2s_tx_stereo. It drives sclk/lrclk like a codec, samples
// i2s_din on every sclk rise, and compares each bit against a scoreboard.
// Expected slot bits are queued as each slot's lrclk edge is driven.
module tb_i2s_tx_stereo;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        sclk, lrclk, in_valid;
    logic [31:0] in_l, in_r;
    logic        rdy0, din0, smp0, und0;
    logic        rdy1, din1, smp1, und1;

    always #5 CLK = ~CLK;

    // I2S, 16-bit samples
    i2s_tx_stereo #(.WIDTH(16), .MODE(0)) d0 (
        .CLK(CLK), .RSTN(RSTN), .IN_L(in_l[15:0]), .IN_R(in_r[15:0]),
        .in_valid(in_valid), .in_ready(rdy0), .i2s_sclk(sclk), .i2s_lrclk(lrclk),
        .i2s_din(din0), .i2s_sampled(smp0), .underrun(und0));

    // left-justified, 24-bit samples
    i2s_tx_stereo #(.WIDTH(24), .MODE(1)) d1 (
        .CLK(CLK), .RSTN(RSTN), .IN_L(in_l[23:0]), .IN_R(in_r[23:0]),
        .in_valid(in_valid), .in_ready(rdy1), .i2s_sclk(sclk), .i2s_lrclk(lrclk),
        .i2s_din(din1), .i2s_sampled(smp1), .underrun(und1));

    int          sel, slot_len, width, mode;
    logic        rdy_sel, din_sel, smp_sel, und_sel;
    int          checks = 0, errors = 0;
    logic        exp_q[$];
    logic [63:0] acc_q[$];
    int          cnt_sampled = 0, cnt_underrun = 0;
    int          exp_sampled = 0, exp_underrun = 0;
    logic [31:0] frame_r;
    bit          stream_on;

    always_comb begin
        rdy_sel = (sel == 0) ? rdy0 : rdy1;
        din_sel = (sel == 0) ? din0 : din1;
        smp_sel = (sel == 0) ? smp0 : smp1;
        und_sel = (sel == 0) ? und0 : und1;
    end

    // Observe the handshake and the pulses away from the active edge.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (in_valid && rdy_sel) acc_q.push_back({in_l, in_r});
            if (smp_sel) cnt_sampled++;
            if (und_sel) cnt_underrun++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (stream_on) begin
            in_l = $urandom;
            in_r = $urandom;
        end
    endtask

    task automatic half_bit();
        repeat (8) tick();
    endtask

    task automatic push_word(input logic [31:0] val);
        for (int j = 0; j < slot_len; j++)
            exp_q.push_back((j < width) ? val[width-1-j] : 1'b0);
    endtask

    // Sample din at the sclk rise and compare it with the next expected bit.
    task automatic rise_and_check();
        logic b;
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check("din_bit", 64'(din_sel), 64'(b));
        sclk = 1'b1;
    endtask

    task automatic do_reset_mid_word();
        int n;
        check("ready_low_before_reset", 64'(rdy_sel), 64'd0);
        repeat (3) tick();
        RSTN = 1'b0;
        #1;
        check("reset_din_zero", 64'(din_sel), 64'd0);
        check("reset_ready_high", 64'(rdy_sel), 64'd1);
        repeat (2) tick();
        RSTN = 1'b1;
        n = exp_q.size();
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
        acc_q.delete();
        frame_r = '0;
    endtask

    task automatic run_slot(input bit left, input int reset_at);
        logic [63:0] p;
        for (int k = 0; k < slot_len; k++) begin
            sclk = 1'b0;
            if (k == 0) begin
                lrclk = left ? (mode == 1) : (mode == 0);
                if (left) begin
                    exp_sampled++;
                    if (stream_on) begin
                        check("accepts_per_frame", 64'(acc_q.size()), 64'd1);
                        check("ready_low_while_full", 64'(rdy_sel), 64'd0);
                    end
                    if (acc_q.size() > 0) begin
                        p = acc_q.pop_front();
                        push_word(p[63:32]);
                        frame_r = p[31:0];
                    end else begin
                        exp_underrun++;
                        push_word('0);
                        frame_r = '0;
                    end
                end else begin
                    push_word(frame_r);
                end
            end
            half_bit();
            rise_and_check();
            if (k == reset_at) do_reset_mid_word();
            half_bit();
        end
    endtask

    task automatic run_frame();
        run_slot(1'b1, -1);
        run_slot(1'b0, -1);
    endtask

    task automatic feed(input logic [31:0] l, input logic [31:0] r);
        int n;
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        n = 0;
        while (!rdy_sel && n < 100) begin
            tick();
            n++;
        end
        check("feed_ready_timeout", 64'(rdy_sel), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_test(input int s, input int len);
        sel       = s;
        slot_len  = len;
        width     = (s == 0) ? 16 : 24;
        mode      = (s == 0) ? 0 : 1;
        stream_on = 1'b0;
        in_valid  = 1'b0;
        RSTN      = 1'b0;
        sclk      = 1'b0;
        lrclk     = (mode == 0);   // idle on the right-channel level
        repeat (3) tick();
        check("rst_din", 64'(din_sel), 64'd0);
        check("rst_ready", 64'(rdy_sel), 64'd1);
        check("rst_sampled", 64'(smp_sel), 64'd0);
        check("rst_underrun", 64'(und_sel), 64'd0);
        exp_q.delete();
        acc_q.delete();
        frame_r = '0;
        RSTN = 1'b1;
        repeat (4) tick();
        // Lead-in bits at the right-channel level; the output must stay silent.
        // In I2S mode the first rise shows the bit before the first slot.
        if (mode == 0) exp_q.push_back(1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
        for (int k = 0; k < 4; k++) begin
            sclk = 1'b0;
            half_bit();
            rise_and_check();
            half_bit();
        end
    endtask

    initial begin
        in_l = '0; in_r = '0; in_valid = 1'b0; sclk = 1'b0; lrclk = 1'b0;
        RSTN = 1'b0; sel = 0; stream_on = 1'b0;

        // I2S, 16-bit, 32-bit slots: pattern with both ends set
        start_test(0, 32);
        feed(32'h8001, 32'h7FFE);
        run_frame();
        // two frames with no data: each must underrun with a silent output
        run_frame();
        check("idle_ready_1", 64'(rdy_sel), 64'd1);
        run_frame();
        check("idle_ready_2", 64'(rdy_sel), 64'd1);
        feed(32'h1234, 32'hC0DE);
        run_frame();
        check("m0_sampled_pulses", 64'(cnt_sampled), 64'(exp_sampled));
        check("m0_underrun_pulses", 64'(cnt_underrun), 64'(exp_underrun));

        // reset in the middle of a right word, then recover
        start_test(0, 32);
        feed(32'h8001, 32'h7FFE);
        run_slot(1'b1, -1);
        feed(32'hAAAA, 32'h5555);
        run_slot(1'b0, 4);
        run_frame();
        feed(32'hF00F, 32'h0FF0);
        run_frame();
        check("rst_sampled_pulses", 64'(cnt_sampled), 64'(exp_sampled));
        check("rst_underrun_pulses", 64'(cnt_underrun), 64'(exp_underrun));

        // left-justified, 24-bit samples in 32-bit slots
        start_test(1, 32);
        feed(32'hABCDEF, 32'h123456);
        run_frame();
        feed(32'hABCDEF, 32'h800001);
        run_frame();
        check("m1_sampled_pulses", 64'(cnt_sampled), 64'(exp_sampled));
        check("m1_underrun_pulses", 64'(cnt_underrun), 64'(exp_underrun));

        // valid held high, with new data on every CLK
        start_test(1, 32);
        stream_on = 1'b1;
        in_valid  = 1'b1;
        repeat (4) tick();
        run_frame();
        run_frame();
        run_frame();
        stream_on = 1'b0;
        in_valid  = 1'b0;
        check("stream_sampled_pulses", 64'(cnt_sampled), 64'(exp_sampled));
        check("stream_underrun_pulses", 64'(cnt_underrun), 64'(exp_underrun));

        // 16-bit slots that are shorter than 24-bit samples
        start_test(1, 16);
        feed(32'hABCDEF, 32'h654321);
        run_frame();
        feed(32'hF00F0F, 32'h0FF0F0);
        run_frame();
        check("short_sampled_pulses", 64'(cnt_sampled), 64'(exp_sampled));
        check("short_underrun_pulses", 64'(cnt_underrun), 64'(exp_underrun));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
